// File: rtl/seg_scan_driver.sv
// Scans a 4-nibble word onto a 4-digit 7-segment display with anti-ghost gaps.
// Latency: the digit-0 slot shows inputs sampled on its own opening edge; other digits use that frame's snapshot.
// Backpressure: none; the display free-runs and the frame cadence never stalls.
//
// Ports: clk, rst (async, active-high); reg_num / dp_position / reg_frac / reg_neg in;
//        an (digit enables), seg {g,f,e,d,c,b,a}, dp, frame_tick out. Pin polarity set by ACTIVE_LOW.
// Optional feature: define DISP_BLINK_EN to blink the display while the error word 16'hBBBB is shown.
module seg_scan_driver #(
    parameter int REFRESH_DIV  = 50000,
    parameter int BLANK_CYC    = 500,
    parameter int ACTIVE_LOW   = 1,
    parameter int BLINK_FRAMES = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] reg_num,
    input  logic [3:0]  dp_position,
    input  logic        reg_frac,
    input  logic        reg_neg,
    output logic [3:0]  an,
    output logic [6:0]  seg,
    output logic        dp,
    output logic        frame_tick
);

    localparam int RW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int BW = (BLANK_CYC > 1) ? $clog2(BLANK_CYC) : 1;
    localparam logic [RW-1:0] SCAN_LAST = RW'(REFRESH_DIV - 1);
    localparam logic [BW-1:0] GAP_LAST  = BW'(BLANK_CYC - 1);
    // Gap count one cycle before the last gap cycle; only meaningful when BLANK_CYC >= 2.
    localparam logic [BW-1:0] GAP_PRE   = BW'((BLANK_CYC >= 2) ? BLANK_CYC - 2 : 0);
    localparam logic INV = (ACTIVE_LOW != 0);

    typedef enum logic {GAP, SCAN} state_t;

    state_t      state;
    logic [BW-1:0] gap_cnt;
    logic [RW-1:0] scan_cnt;
    logic [1:0]  idx;
    logic [15:0] snap_num;
    logic [3:0]  snap_dp;
    logic        snap_frac;
    logic        snap_neg_unused;   // captured with the frame for coherence; nothing here consumes it

    logic        gap_last, scan_last, take_snap, tick_nxt, an_gate;
    logic [15:0] cur_num;
    logic [3:0]  cur_dp;
    logic        cur_frac;
    logic [3:0]  nib;
    logic [6:0]  seg_log;
    logic        dp_log;
    logic [3:0]  an_log;

    assign gap_last  = (state == GAP)  && (gap_cnt == GAP_LAST);
    assign scan_last = (state == SCAN) && (scan_cnt == SCAN_LAST);
    assign take_snap = gap_last && (idx == 2'd0);

    // frame_tick is registered, so it is set on the edge entering the last cycle of the digit-0 gap.
    // With a single-cycle gap that edge is the end of the digit-3 slot.
    assign tick_nxt = (BLANK_CYC == 1) ? (scan_last && (idx == 2'd3))
                                       : ((state == GAP) && (idx == 2'd0) && (gap_cnt == GAP_PRE));

    // Digit 0 is loaded on the snapshot edge itself, so it must see the live inputs.
    always_comb begin
        cur_num  = take_snap ? reg_num     : snap_num;
        cur_dp   = take_snap ? dp_position : snap_dp;
        cur_frac = take_snap ? reg_frac    : snap_frac;
        nib      = cur_num[{idx, 2'b00} +: 4];
        case (nib)
            4'd0:    seg_log = 7'h3F;
            4'd1:    seg_log = 7'h06;
            4'd2:    seg_log = 7'h5B;
            4'd3:    seg_log = 7'h4F;
            4'd4:    seg_log = 7'h66;
            4'd5:    seg_log = 7'h6D;
            4'd6:    seg_log = 7'h7D;
            4'd7:    seg_log = 7'h07;
            4'd8:    seg_log = 7'h7F;
            4'd9:    seg_log = 7'h6F;
            4'd11:   seg_log = 7'h40;
            default: seg_log = 7'h00;
        endcase
        dp_log = cur_frac & cur_dp[idx];
        an_log = (4'b0001 << idx) & {4{an_gate}};
    end

`ifdef DISP_BLINK_EN
    localparam int BFW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [BFW-1:0] BF_LAST = BFW'(BLINK_FRAMES - 1);

    logic [BFW-1:0] blink_cnt, blink_cnt_nxt;
    logic           blink_on, blink_on_nxt;

    // Frames are counted at each frame start while the error word persists; the first error
    // frame starts the count from zero in the ON phase.
    always_comb begin
        blink_cnt_nxt = blink_cnt;
        blink_on_nxt  = blink_on;
        if (take_snap) begin
            if (reg_num != 16'hBBBB) begin
                blink_cnt_nxt = '0;
                blink_on_nxt  = 1'b1;
            end else if (snap_num == 16'hBBBB) begin
                if (blink_cnt == BF_LAST) begin
                    blink_cnt_nxt = '0;
                    blink_on_nxt  = ~blink_on;
                end else begin
                    blink_cnt_nxt = blink_cnt + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            blink_cnt <= '0;
            blink_on  <= 1'b1;
        end else begin
            blink_cnt <= blink_cnt_nxt;
            blink_on  <= blink_on_nxt;
        end
    end

    assign an_gate = blink_on_nxt;
`else
    localparam int blink_frames_unused = BLINK_FRAMES;
    assign an_gate = 1'b1;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state           <= GAP;
            gap_cnt         <= '0;
            scan_cnt        <= '0;
            idx             <= 2'd0;
            snap_num        <= '0;
            snap_dp         <= '0;
            snap_frac       <= 1'b0;
            snap_neg_unused <= 1'b0;
            an              <= {4{INV}};
            seg             <= {7{INV}};
            dp              <= INV;
            frame_tick      <= 1'b0;
        end else begin
            frame_tick <= tick_nxt;
            case (state)
                GAP: begin
                    if (gap_last) begin
                        state   <= SCAN;
                        gap_cnt <= '0;
                        an      <= an_log  ^ {4{INV}};
                        seg     <= seg_log ^ {7{INV}};
                        dp      <= dp_log  ^ INV;
                        if (take_snap) begin
                            snap_num        <= reg_num;
                            snap_dp         <= dp_position;
                            snap_frac       <= reg_frac;
                            snap_neg_unused <= reg_neg;
                        end
                    end else begin
                        gap_cnt <= gap_cnt + 1'b1;
                    end
                end
                SCAN: begin
                    if (scan_last) begin
                        state    <= GAP;
                        scan_cnt <= '0;
                        idx      <= idx + 2'd1;
                        an       <= {4{INV}};
                        seg      <= {7{INV}};
                        dp       <= INV;
                    end else begin
                        scan_cnt <= scan_cnt + 1'b1;
                    end
                end
                default: state <= GAP;
            endcase
        end
    end

endmodule

// File: tb/tb_seg_scan_driver.sv
// Bench for seg_scan_driver with REFRESH_DIV=4, BLANK_CYC=2, ACTIVE_LOW=1 (24-cycle frame).
// Expected pins come from a frame-position model: position in frame -> gap or lit digit,
// values taken from a per-frame snapshot of the inputs and the segment table.
module tb_seg_scan_driver;

    localparam int FRAME = 24;
    localparam int SLOT  = 6;
    localparam int GAPC  = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] reg_num;
    logic [3:0]  dp_position;
    logic        reg_frac;
    logic        reg_neg;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        dp;
    logic        frame_tick;

    int checks = 0;
    int failures = 0;
    int t;
    logic [15:0] m_num;
    logic [3:0]  m_dp;
    logic        m_frac;

    // Logical segment patterns {g..a} indexed by nibble.
    logic [6:0] dec_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                 7'h7F, 7'h6F, 7'h00, 7'h40, 7'h00, 7'h00, 7'h00, 7'h00};

    seg_scan_driver #(
        .REFRESH_DIV (4),
        .BLANK_CYC   (2),
        .ACTIVE_LOW  (1),
        .BLINK_FRAMES(2)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .reg_num    (reg_num),
        .dp_position(dp_position),
        .reg_frac   (reg_frac),
        .reg_neg    (reg_neg),
        .an         (an),
        .seg        (seg),
        .dp         (dp),
        .frame_tick (frame_tick)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s t=%0d got=%h exp=%h", tag, t, got, exp);
        end
    endtask

    // Called at a falling edge: compare pins for cycle t, then advance one clock.
    task automatic step();
        int p, k;
        logic [3:0] ea;
        logic [6:0] es;
        logic       ed;
        p = t % FRAME;
        k = p / SLOT;
        if ((p % SLOT) < GAPC) begin
            ea = 4'hF;
            es = 7'h7F;
            ed = 1'b1;
        end else begin
            ea = ~(4'b0001 << k);
            es = ~dec_tab[m_num[4*k +: 4]];
            ed = ~(m_frac & m_dp[k]);
        end
        chk("an", {12'h0, an}, {12'h0, ea});
        chk("seg", {9'h0, seg}, {9'h0, es});
        chk("dp", {15'h0, dp}, {15'h0, ed});
        chk("frame_tick", {15'h0, frame_tick}, 16'(p == 1));
        // The next rising edge opens digit 0 and captures the inputs for the new frame.
        if (p == 1) begin
            m_num  = reg_num;
            m_dp   = dp_position;
            m_frac = reg_frac;
        end
        @(posedge clk);
        t++;
        @(negedge clk);
    endtask

    task automatic rand_inputs();
        reg_num     = ($urandom_range(3) == 0) ? 16'hBBBB : 16'($urandom);
        dp_position = 4'($urandom);
        reg_frac    = 1'($urandom);
        reg_neg     = 1'($urandom);
    endtask

    initial begin
        rst = 1'b1;
        reg_num = 16'h1234;
        dp_position = 4'b0000;
        reg_frac = 1'b0;
        reg_neg = 1'b0;
        t = 0;
        m_num = '0;
        m_dp = '0;
        m_frac = 1'b0;

        repeat (3) @(negedge clk);
        chk("rst_an", {12'h0, an}, 16'h000F);
        chk("rst_seg", {9'h0, seg}, 16'h007F);
        chk("rst_dp", {15'h0, dp}, 16'h0001);
        chk("rst_tick", {15'h0, frame_tick}, 16'h0000);

        // 1234 from reset, then 5678 arrives mid digit-2 slot and shows only from the next frame.
        rst = 1'b0;
        t = 0;
        while (t < 2 * FRAME) begin
            if (t == 14) reg_num = 16'h5678;
            step();
        end

        // Minus, blank and a single decimal point, then the same word with the point disabled.
        reg_num = 16'hBA35;
        dp_position = 4'b0010;
        reg_frac = 1'b1;
        repeat (2 * FRAME) step();
        reg_frac = 1'b0;
        repeat (FRAME) step();

        // All decimal points lit, all digits 9/8/0.
        reg_num = 16'h9800;
        dp_position = 4'b1111;
        reg_frac = 1'b1;
        repeat (FRAME) step();

        // Asynchronous reset in the middle of the digit-1 slot blanks pins before any edge.
        while ((t % FRAME) != 9) step();
        #2 rst = 1'b1;
        #1;
        chk("arst_an", {12'h0, an}, 16'h000F);
        chk("arst_seg", {9'h0, seg}, 16'h007F);
        chk("arst_dp", {15'h0, dp}, 16'h0001);
        chk("arst_tick", {15'h0, frame_tick}, 16'h0000);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        t = 0;
        repeat (2 * FRAME) step();

        // Random words and flags, changing at arbitrary cycles.
        repeat (40 * FRAME) begin
            if ($urandom_range(7) == 0) rand_inputs();
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
